// File: rtl/sonic_tx_page_unpacker_66.sv
// sonic_tx_page_unpacker_66
//
// Transmit-side page unpacker. Each DMA page starts with HDR_WORDS words of
// packed 2-bit sync headers, followed by 128-bit payload words. Each payload
// word holds two 64-bit blocks. This module rejoins every payload with its sync
// header and emits the 66-bit blocks in order under a valid/ready handshake.
//
// Ports
//   clk_in     rising-edge clock
//   reset      asynchronous, active-high; clears all state
//   data_in    128-bit page word from DMA
//   in_valid   data_in is valid
//   in_ready   word accepted when in_valid && in_ready
//   data_out   {payload[63:0], sync[1:0]}
//   out_valid  data_out holds a block
//   out_ready  block consumed when out_valid && out_ready
//   page_done  one-cycle pulse after the last block of a page is consumed
//   sync_err   one-cycle pulse after a block with sync 2'b00 or 2'b11 is consumed

module sonic_tx_page_unpacker_66 #(
    parameter int unsigned HDR_WORDS       = 8,
    parameter int unsigned PAGE_WORDS      = 256,
    parameter int unsigned BLOCKS_PER_PAGE = 496
) (
    input  logic         clk_in,
    input  logic         reset,
    input  logic [127:0] data_in,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [65:0]  data_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         page_done,
    output logic         sync_err
);

    localparam int unsigned HdrBits = 128 * HDR_WORDS;
    localparam int unsigned HdrIdxW = $clog2(HdrBits);
    localparam int unsigned SlotW   = $clog2(HDR_WORDS);
    localparam int unsigned WcntW   = $clog2(PAGE_WORDS);
    localparam int unsigned BidxW   = $clog2(BLOCKS_PER_PAGE);

    typedef enum logic [1:0] {StHdr, StLoad, StEmitLo, StEmitHi} state_e;

    state_e               state;
    logic [HdrBits-1:0]   hdr_reg;
    logic [127:0]         word_reg;
    logic [WcntW-1:0]     wcnt;
    logic [BidxW-1:0]     bidx;

    logic                 in_fire;
    logic                 out_fire;
    logic                 last_blk;
    logic [1:0]           cur_sync;
    logic [HdrIdxW-1:0]   hdr_base;
    logic [HdrIdxW-1:0]   sync_base;

    // Header word h lands at bit 128*h; sync for block k sits at bit 2*k.
    assign hdr_base  = HdrIdxW'({wcnt[SlotW-1:0], 7'd0});
    assign sync_base = HdrIdxW'({bidx, 1'b0});
    assign cur_sync  = hdr_reg[sync_base +: 2];
    assign last_blk  = (bidx == BidxW'(BLOCKS_PER_PAGE - 1));
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            StHdr, StLoad: in_ready = 1'b1;
            StEmitLo:      out_valid = 1'b1;
            StEmitHi: begin
                out_valid = 1'b1;
                // Refill alongside the high block so words stream without a
                // bubble, but never pull the next page's header in early.
                in_ready  = out_ready && !last_blk;
            end
            default: ;
        endcase
        data_out = {(state == StEmitHi) ? word_reg[127:64] : word_reg[63:0], cur_sync};
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state     <= StHdr;
            hdr_reg   <= '0;
            word_reg  <= '0;
            wcnt      <= '0;
            bidx      <= '0;
            page_done <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            page_done <= 1'b0;
            sync_err  <= 1'b0;
            if (in_fire) begin
                wcnt <= wcnt + WcntW'(1);
            end
            if (out_fire) begin
                sync_err <= (cur_sync == 2'b00) || (cur_sync == 2'b11);
            end
            unique case (state)
                StHdr: begin
                    if (in_fire) begin
                        hdr_reg[hdr_base +: 128] <= data_in;
                        if (wcnt == WcntW'(HDR_WORDS - 1)) begin
                            state <= StLoad;
                        end
                    end
                end
                StLoad: begin
                    if (in_fire) begin
                        word_reg <= data_in;
                        state    <= StEmitLo;
                    end
                end
                StEmitLo: begin
                    if (out_fire) begin
                        bidx  <= bidx + BidxW'(1);
                        state <= StEmitHi;
                    end
                end
                StEmitHi: begin
                    if (out_fire) begin
                        if (last_blk) begin
                            bidx      <= '0;
                            wcnt      <= '0;
                            page_done <= 1'b1;
                            state     <= StHdr;
                        end else begin
                            bidx <= bidx + BidxW'(1);
                            if (in_fire) begin
                                word_reg <= data_in;
                                state    <= StEmitLo;
                            end else begin
                                state <= StLoad;
                            end
                        end
                    end
                end
                default: state <= StHdr;
            endcase
        end
    end

endmodule

// File: tb/tb_sonic_tx_page_unpacker_66.sv
module tb_sonic_tx_page_unpacker_66;

    logic         clk_in = 1'b0;
    logic         reset;
    logic [127:0] data_in;
    logic         in_valid;
    logic         in_ready;
    logic [65:0]  data_out;
    logic         out_valid;
    logic         out_ready;
    logic         page_done;
    logic         sync_err;

    int n_vec = 0;
    int n_err = 0;

    // Per-run statistics.
    int pd_seen;
    int se_seen;
    int t_first;
    int t_last0;
    int t_last1;

    sonic_tx_page_unpacker_66 dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .data_in   (data_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .page_done (page_done),
        .sync_err  (sync_err)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // mode 0: every sync 01. mode 1: block 3 -> 00, block 200 -> 11, rest 10,
    // unused header bits filled with 11 (must be ignored).
    function automatic logic [1:0] sync_of(input int mode, input int k);
        if (mode == 0) return 2'b01;
        if (k >= 496) return 2'b11;
        if (k == 3) return 2'b00;
        if (k == 200) return 2'b11;
        return 2'b10;
    endfunction

    function automatic logic [63:0] pay_of(input int p, input int k);
        return (64'(p) << 32) | 64'(k);
    endfunction

    function automatic logic [65:0] exp_blk(input int p, input int k, input int mode);
        return {pay_of(p, k), sync_of(mode, k)};
    endfunction

    function automatic logic [127:0] word_of(input int p, input int w, input int mode);
        logic [127:0] r;
        r = '0;
        if (w < 8) begin
            for (int b = 0; b < 64; b++) r[2*b +: 2] = sync_of(mode, 64 * w + b);
        end else begin
            r = {pay_of(p, 2 * (w - 8) + 1), pay_of(p, 2 * (w - 8))};
        end
        return r;
    endfunction

    // Streams npages pages (ids pbase..) and checks every consumed block,
    // stalls, in_ready rules and pulses. Stops early after max_blocks consumes.
    task automatic run(input int pbase, input int npages, input int mode, input bit rnd,
                       input int max_blocks);
        int send_p = 0, send_w = 0, recv_p = 0, recv_k = 0, consumed = 0, cyc = 0;
        bit exp_pd = 0, exp_se = 0, held_v = 0, inf, outf;
        logic [65:0] held_d = '0;
        pd_seen = 0; se_seen = 0; t_first = -1; t_last0 = -1; t_last1 = -1;
        @(negedge clk_in);
        while (recv_p < npages && consumed < max_blocks && cyc < 4000 * npages) begin
            check("page_done", 66'(page_done), 66'(exp_pd));
            check("sync_err", 66'(sync_err), 66'(exp_se));
            if (page_done) pd_seen++;
            if (sync_err) se_seen++;
            exp_pd = 0; exp_se = 0;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid  = (send_p < npages) && (!rnd || ($urandom_range(0, 3) != 0));
            data_in   = word_of(pbase + send_p, send_w, mode);
            #1;
            if (held_v) begin
                check("stall_valid", 66'(out_valid), 66'(1));
                check("stall_data", data_out, held_d);
            end
            if (!out_valid) check("in_ready_idle", 66'(in_ready), 66'(1));
            else if (recv_k % 2 == 0 || recv_k == 495) check("in_ready_blk", 66'(in_ready), 66'(0));
            else check("in_ready_hi", 66'(in_ready), 66'(out_ready));
            held_v = out_valid && !out_ready;
            held_d = data_out;
            inf  = in_valid && in_ready;
            outf = out_valid && out_ready;
            if (outf) begin
                check("block", data_out, exp_blk(pbase + recv_p, recv_k, mode));
                exp_se = (sync_of(mode, recv_k) == 2'b00) || (sync_of(mode, recv_k) == 2'b11);
                consumed++;
                if (recv_k == 495) begin
                    exp_pd = 1;
                    if (recv_p == 0) t_last0 = cyc;
                    if (recv_p == 1) t_last1 = cyc;
                    recv_p++;
                    recv_k = 0;
                end else begin
                    recv_k++;
                end
            end
            if (inf) begin
                if (t_first < 0) t_first = cyc;
                send_w++;
                if (send_w == 256) begin
                    send_w = 0;
                    send_p++;
                end
            end
            @(negedge clk_in);
            cyc++;
        end
        check("page_done_tail", 66'(page_done), 66'(exp_pd));
        check("sync_err_tail", 66'(sync_err), 66'(exp_se));
        if (page_done) pd_seen++;
        if (sync_err) se_seen++;
        if (max_blocks > 496 * npages) check("no_timeout", 66'(recv_p), 66'(npages));
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_in   = '0;
        #1;
        check("rst_out_valid", 66'(out_valid), 66'(0));
        check("rst_in_ready", 66'(in_ready), 66'(1));
        check("rst_data_out", data_out, 66'h0);
        check("rst_page_done", 66'(page_done), 66'(0));
        check("rst_sync_err", 66'(sync_err), 66'(0));
        repeat (2) @(negedge clk_in);
        reset = 1'b0;

        // Continuous streaming, two back-to-back pages: 8 + 1 + 496 cycles each.
        run(0, 2, 0, 1'b0, 1 << 30);
        check("pages_A", 66'(pd_seen), 66'(2));
        check("no_sync_err_A", 66'(se_seen), 66'(0));
        check("page_span", 66'(t_last0 - t_first + 1), 66'(505));
        check("page_period", 66'(t_last1 - t_last0), 66'(505));

        // Random stalls and gaps over four pages.
        run(10, 4, 0, 1'b1, 1 << 30);
        check("pages_B", 66'(pd_seen), 66'(4));
        check("no_sync_err_B", 66'(se_seen), 66'(0));

        // Bad sync on blocks 3 and 200.
        run(20, 1, 1, 1'b1, 1 << 30);
        check("pages_C", 66'(pd_seen), 66'(1));
        check("sync_err_count", 66'(se_seen), 66'(2));

        // Abort a page after 100 blocks, then a fresh page must start at k=0.
        run(7, 1, 0, 1'b0, 100);
        reset = 1'b1;
        #1;
        check("mid_rst_out_valid", 66'(out_valid), 66'(0));
        check("mid_rst_in_ready", 66'(in_ready), 66'(1));
        check("mid_rst_data_out", data_out, 66'h0);
        @(negedge clk_in);
        reset = 1'b0;
        run(8, 1, 0, 1'b1, 1 << 30);
        check("pages_D", 66'(pd_seen), 66'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
